ifm_chunk_bank_ring: RTL and testbench

//  N-bank IFM chunk buffer that generalises the two-bank ping-pong. Banks are

---
 rtl/ifm_chunk_bank_ring.sv | 241 ++++++++++++++++++++++++
 tb/tb_ifm_chunk_bank_ring.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifm_chunk_bank_ring.sv
// Ring of NUM_BANKS IFM chunk buffers: the loader fills banks in ring order and
// the PE read path drains them in the same order, with occupancy tracked here.

module data_chunk #(
  parameter int BUS_SIZE        = 32,
  parameter int CHUNK_SIZE      = 128,
  parameter int PREFIX_SUM_SIZE = 32,
  parameter int WR_BEATS        = CHUNK_SIZE / BUS_SIZE,
  parameter int BEAT_W          = 2,
  parameter int DA_W            = 8,
  parameter int SM_W            = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [BEAT_W-1:0]          wr_beat_i,
  input  logic [BUS_SIZE-1:0]        wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]      wr_data_i,
  input  logic [DA_W-1:0]            rd_dat_addr_i,
  output logic [7:0]                 rd_data_o,
  input  logic [SM_W-1:0]            rd_sparsemap_addr_i,
  output logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_o
);

  localparam int BYTE_W = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;
  localparam int SUBW   = BUS_SIZE / PREFIX_SUM_SIZE;
  localparam int SUB_W  = (SUBW > 1) ? $clog2(SUBW) : 1;

  // One memory word per write beat; narrow reads select inside the registered word.
  logic [BUS_SIZE*8-1:0] data_mem [WR_BEATS];
  logic [BUS_SIZE-1:0]   smap_mem [WR_BEATS];

  logic [BEAT_W-1:0]     dat_beat;
  logic [BEAT_W-1:0]     sm_beat;
  logic [BYTE_W-1:0]     dat_byte;
  logic [SUB_W-1:0]      sm_sub;
  logic                  dat_in_range;

  logic [BUS_SIZE*8-1:0] data_word_reg;
  logic [BYTE_W-1:0]     byte_sel_reg;
  logic                  in_range_reg;
  logic [BUS_SIZE-1:0]   smap_word_reg;
  logic [SUB_W-1:0]      sub_sel_reg;

  always_comb begin
    dat_beat     = BEAT_W'(32'(rd_dat_addr_i) / BUS_SIZE);
    dat_byte     = BYTE_W'(32'(rd_dat_addr_i) % BUS_SIZE);
    dat_in_range = (32'(rd_dat_addr_i) < CHUNK_SIZE);
    sm_beat      = BEAT_W'(32'(rd_sparsemap_addr_i) / SUBW);
    sm_sub       = SUB_W'(32'(rd_sparsemap_addr_i) % SUBW);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_mem[wr_beat_i] <= wr_data_i;
      smap_mem[wr_beat_i] <= wr_sparsemap_i;
    end
  end

  // Array contents are not cleared: a bank only becomes readable after all of
  // its beats are rewritten, so only the read registers need a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_word_reg <= '0;
      byte_sel_reg  <= '0;
      in_range_reg  <= 1'b0;
      smap_word_reg <= '0;
      sub_sel_reg   <= '0;
    end else begin
      data_word_reg <= data_mem[dat_beat];
      byte_sel_reg  <= dat_byte;
      in_range_reg  <= dat_in_range;
      smap_word_reg <= smap_mem[sm_beat];
      sub_sel_reg   <= sm_sub;
    end
  end

  always_comb begin
    rd_data_o      = in_range_reg ? data_word_reg[byte_sel_reg*8 +: 8] : 8'h00;
    rd_sparsemap_o = smap_word_reg[sub_sel_reg*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
  end

endmodule

module ifm_chunk_bank_ring #(
  parameter int NUM_BANKS       = 4,
  parameter int BUS_SIZE        = 32,
  parameter int CHUNK_SIZE      = 128,
  parameter int PREFIX_SUM_SIZE = 32,
  parameter int WR_BEATS        = CHUNK_SIZE / BUS_SIZE,
  parameter int RD_WORDS        = CHUNK_SIZE / PREFIX_SUM_SIZE
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [BUS_SIZE-1:0]                wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]              wr_nonzero_data_i,
  input  logic                               wr_valid_i,
  output logic                               wr_ready_o,
  input  logic                               wr_abort_i,
  output logic [$clog2(NUM_BANKS)-1:0]       wr_bank_o,
  output logic                               rd_bank_valid_o,
  output logic [$clog2(NUM_BANKS)-1:0]       rd_bank_o,
  input  logic                               rd_release_i,
  input  logic [$clog2(CHUNK_SIZE):0]        rd_dat_addr_i,
  output logic [7:0]                         rd_data_o,
  input  logic [$clog2(RD_WORDS)-1:0]        rd_sparsemap_addr_i,
  output logic [PREFIX_SUM_SIZE-1:0]         rd_sparsemap_o,
  output logic [$clog2(NUM_BANKS):0]         occupancy_o,
  output logic                               err_o
);

  localparam int PTR_W  = $clog2(NUM_BANKS);
  localparam int OCC_W  = PTR_W + 1;
  localparam int DA_W   = $clog2(CHUNK_SIZE) + 1;
  localparam int SM_W   = $clog2(RD_WORDS);
  localparam int BEAT_W = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [OCC_W-1:0]  occ_reg, occ_next;
  logic              err_reg, err_next;

  logic wr_ready;
  logic rd_valid;
  logic wr_accept;
  logic fill_done;
  logic release_ok;

  logic [7:0]                 bank_rd_data [NUM_BANKS];
  logic [PREFIX_SUM_SIZE-1:0] bank_rd_smap [NUM_BANKS];

  always_comb begin
    wr_ready   = (occ_reg < OCC_W'(NUM_BANKS));
    rd_valid   = (occ_reg != '0);
    wr_accept  = wr_valid_i && wr_ready && !wr_abort_i;
    fill_done  = wr_accept && (beat_cnt_reg == BEAT_W'(WR_BEATS - 1));
    release_ok = rd_release_i && rd_valid;
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    occ_next      = occ_reg;
    err_next      = err_reg;

    if (wr_abort_i) begin
      beat_cnt_next = '0;
    end else if (wr_accept) begin
      if (fill_done) begin
        beat_cnt_next = '0;
        wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
      end else begin
        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
      end
    end

    if (release_ok) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end

    // A completion and a release in the same cycle cancel out.
    if (fill_done && !release_ok) begin
      occ_next = occ_reg + OCC_W'(1);
    end else if (!fill_done && release_ok) begin
      occ_next = occ_reg - OCC_W'(1);
    end

    if ((wr_valid_i && !wr_ready) || (rd_release_i && !rd_valid)) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      occ_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      occ_reg      <= occ_next;
      err_reg      <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic             is_head;
      logic             bank_wr_en;
      logic [DA_W-1:0]  bank_dat_addr;
      logic [SM_W-1:0]  bank_sm_addr;

      // Non-head banks park on an out-of-range address so they read back zero.
      always_comb begin
        is_head       = (rd_ptr_reg == PTR_W'(gi));
        bank_wr_en    = wr_accept && (wr_ptr_reg == PTR_W'(gi));
        bank_dat_addr = is_head ? rd_dat_addr_i : '1;
        bank_sm_addr  = is_head ? rd_sparsemap_addr_i : '0;
      end

      data_chunk #(
        .BUS_SIZE        (BUS_SIZE),
        .CHUNK_SIZE      (CHUNK_SIZE),
        .PREFIX_SUM_SIZE (PREFIX_SUM_SIZE),
        .WR_BEATS        (WR_BEATS),
        .BEAT_W          (BEAT_W),
        .DA_W            (DA_W),
        .SM_W            (SM_W)
      ) u_chunk (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .wr_en_i             (bank_wr_en),
        .wr_beat_i           (beat_cnt_reg),
        .wr_sparsemap_i      (wr_sparsemap_i),
        .wr_data_i           (wr_nonzero_data_i),
        .rd_dat_addr_i       (bank_dat_addr),
        .rd_data_o           (bank_rd_data[gi]),
        .rd_sparsemap_addr_i (bank_sm_addr),
        .rd_sparsemap_o      (bank_rd_smap[gi])
      );
    end
  endgenerate

  always_comb begin
    wr_ready_o      = wr_ready;
    wr_bank_o       = wr_ptr_reg;
    rd_bank_valid_o = rd_valid;
    rd_bank_o       = rd_ptr_reg;
    occupancy_o     = occ_reg;
    err_o           = err_reg;
    rd_data_o       = rd_valid ? bank_rd_data[rd_ptr_reg] : 8'h00;
    rd_sparsemap_o  = rd_valid ? bank_rd_smap[rd_ptr_reg] : '0;
  end

endmodule

// File: tb/tb_ifm_chunk_bank_ring.sv
// Directed bench for ifm_chunk_bank_ring: ring fill/drain, abort, error flag,
// same-cycle fill+release and reset mid-fill, all against hand-computed values.

module tb_ifm_chunk_bank_ring;

  localparam int NUM_BANKS = 4;
  localparam int BUS_SIZE  = 32;
  localparam int CHUNK     = 128;
  localparam int PSS       = 32;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [BUS_SIZE-1:0]   wr_sparsemap_i = '0;
  logic [BUS_SIZE*8-1:0] wr_nonzero_data_i = '0;
  logic                  wr_valid_i = 1'b0;
  logic                  wr_ready_o;
  logic                  wr_abort_i = 1'b0;
  logic [1:0]            wr_bank_o;
  logic                  rd_bank_valid_o;
  logic [1:0]            rd_bank_o;
  logic                  rd_release_i = 1'b0;
  logic [7:0]            rd_dat_addr_i = '0;
  logic [7:0]            rd_data_o;
  logic [1:0]            rd_sparsemap_addr_i = '0;
  logic [PSS-1:0]        rd_sparsemap_o;
  logic [2:0]            occupancy_o;
  logic                  err_o;

  int vectors = 0;
  int miscompares = 0;

  ifm_chunk_bank_ring #(
    .NUM_BANKS(NUM_BANKS), .BUS_SIZE(BUS_SIZE), .CHUNK_SIZE(CHUNK), .PREFIX_SUM_SIZE(PSS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_sparsemap_i(wr_sparsemap_i), .wr_nonzero_data_i(wr_nonzero_data_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_abort_i(wr_abort_i),
    .wr_bank_o(wr_bank_o), .rd_bank_valid_o(rd_bank_valid_o), .rd_bank_o(rd_bank_o),
    .rd_release_i(rd_release_i), .rd_dat_addr_i(rd_dat_addr_i), .rd_data_o(rd_data_o),
    .rd_sparsemap_addr_i(rd_sparsemap_addr_i), .rd_sparsemap_o(rd_sparsemap_o),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic put_beat(input logic [7:0] val, input int b, input logic rel);
    wr_valid_i        = 1'b1;
    wr_nonzero_data_i = {BUS_SIZE{val}};
    wr_sparsemap_i    = {val, 8'h00, 8'(b), 8'hA5};
    rd_release_i      = rel;
    tick();
    wr_valid_i   = 1'b0;
    rd_release_i = 1'b0;
  endtask

  task automatic fill_chunk(input logic [7:0] val);
    for (int b = 0; b < 4; b++) put_beat(val, b, 1'b0);
    $display("fill  val=%02h -> occ=%0d wr_bank=%0d rd_bank=%0d", val, occupancy_o, wr_bank_o, rd_bank_o);
  endtask

  task automatic release_head();
    rd_release_i = 1'b1;
    tick();
    rd_release_i = 1'b0;
    $display("release -> occ=%0d rd_bank=%0d err=%0d", occupancy_o, rd_bank_o, err_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    $display("reset -> occ=%0d err=%0d", occupancy_o, err_o);
    vectors++; if (occupancy_o !== 3'd0) begin $display("FAIL reset_occ got %0d expected 0", occupancy_o); miscompares++; end
    vectors++; if (err_o !== 1'b0) begin $display("FAIL reset_err got %0b expected 0", err_o); miscompares++; end
    vectors++; if (wr_ready_o !== 1'b1) begin $display("FAIL reset_ready got %0b expected 1", wr_ready_o); miscompares++; end
    vectors++; if (rd_bank_valid_o !== 1'b0) begin $display("FAIL reset_rdvalid got %0b expected 0", rd_bank_valid_o); miscompares++; end
    vectors++; if ({wr_bank_o, rd_bank_o} !== 4'h0) begin $display("FAIL reset_ptrs got %0d/%0d expected 0/0", wr_bank_o, rd_bank_o); miscompares++; end
    vectors++; if (rd_data_o !== 8'h00 || rd_sparsemap_o !== '0) begin $display("FAIL reset_rddata got %02h/%08h expected 0/0", rd_data_o, rd_sparsemap_o); miscompares++; end
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 4; k++) begin
      fill_chunk(8'hA0 + 8'(k));
      vectors++; if (occupancy_o !== 3'(k + 1)) begin $display("FAIL fill_occ got %0d expected %0d", occupancy_o, k + 1); miscompares++; end
    end
    vectors++; if (wr_ready_o !== 1'b0) begin $display("FAIL full_ready got %0b expected 0", wr_ready_o); miscompares++; end
    vectors++; if (wr_bank_o !== 2'd0 || rd_bank_o !== 2'd0) begin $display("FAIL full_ptrs got %0d/%0d expected 0/0", wr_bank_o, rd_bank_o); miscompares++; end
    rd_dat_addr_i = 8'd5; rd_sparsemap_addr_i = 2'd2; tick();
    vectors++; if (rd_data_o !== 8'hA0) begin $display("FAIL head_data got %02h expected a0", rd_data_o); miscompares++; end
    vectors++; if (rd_sparsemap_o !== 32'hA00002A5) begin $display("FAIL head_smap got %08h expected a00002a5", rd_sparsemap_o); miscompares++; end
    rd_dat_addr_i = 8'd127; tick();
    vectors++; if (rd_data_o !== 8'hA0) begin $display("FAIL addr127 got %02h expected a0", rd_data_o); miscompares++; end
    rd_dat_addr_i = 8'd128; tick();
    vectors++; if (rd_data_o !== 8'h00) begin $display("FAIL addr128 got %02h expected 00", rd_data_o); miscompares++; end
  endtask

  task automatic test_release_from_full();
    rd_dat_addr_i = 8'd0;
    release_head();
    vectors++; if (occupancy_o !== 3'd3) begin $display("FAIL rel_occ got %0d expected 3", occupancy_o); miscompares++; end
    vectors++; if (wr_ready_o !== 1'b1) begin $display("FAIL rel_ready got %0b expected 1", wr_ready_o); miscompares++; end
    vectors++; if (rd_bank_o !== 2'd1) begin $display("FAIL rel_rdbank got %0d expected 1", rd_bank_o); miscompares++; end
    tick();
    vectors++; if (rd_data_o !== 8'hA1) begin $display("FAIL rel_data got %02h expected a1", rd_data_o); miscompares++; end
  endtask

  task automatic test_back_to_back();
    release_head();
    for (int b = 0; b < 3; b++) put_beat(8'hC0, b, 1'b0);
    put_beat(8'hC0, 3, 1'b1);
    $display("fill+release -> occ=%0d wr_bank=%0d rd_bank=%0d", occupancy_o, wr_bank_o, rd_bank_o);
    vectors++; if (occupancy_o !== 3'd2) begin $display("FAIL b2b_occ got %0d expected 2", occupancy_o); miscompares++; end
    vectors++; if (wr_bank_o !== 2'd1 || rd_bank_o !== 2'd3) begin $display("FAIL b2b_ptrs got %0d/%0d expected 1/3", wr_bank_o, rd_bank_o); miscompares++; end
  endtask

  task automatic test_abort();
    put_beat(8'hEE, 0, 1'b0);
    put_beat(8'hEE, 1, 1'b0);
    wr_abort_i = 1'b1; wr_valid_i = 1'b1; tick();
    wr_abort_i = 1'b0; wr_valid_i = 1'b0;
    $display("abort -> occ=%0d wr_bank=%0d", occupancy_o, wr_bank_o);
    vectors++; if (wr_bank_o !== 2'd1 || occupancy_o !== 3'd2) begin $display("FAIL abort_state got bank %0d occ %0d expected 1/2", wr_bank_o, occupancy_o); miscompares++; end
    for (int b = 0; b < 3; b++) put_beat(8'hB1, b, 1'b0);
    vectors++; if (occupancy_o !== 3'd2) begin $display("FAIL abort_3beats occ got %0d expected 2", occupancy_o); miscompares++; end
    put_beat(8'hB1, 3, 1'b0);
    vectors++; if (occupancy_o !== 3'd3 || wr_bank_o !== 2'd2) begin $display("FAIL abort_refill got occ %0d bank %0d expected 3/2", occupancy_o, wr_bank_o); miscompares++; end
    release_head();
    release_head();
    vectors++; if (rd_bank_o !== 2'd1 || occupancy_o !== 3'd1) begin $display("FAIL abort_drain got bank %0d occ %0d expected 1/1", rd_bank_o, occupancy_o); miscompares++; end
    rd_dat_addr_i = 8'd0; rd_sparsemap_addr_i = 2'd0; tick();
    vectors++; if (rd_data_o !== 8'hB1) begin $display("FAIL abort_beat0 got %02h expected b1", rd_data_o); miscompares++; end
    vectors++; if (rd_sparsemap_o !== 32'hB10000A5) begin $display("FAIL abort_smap0 got %08h expected b10000a5", rd_sparsemap_o); miscompares++; end
    rd_dat_addr_i = 8'd40; tick();
    vectors++; if (rd_data_o !== 8'hB1) begin $display("FAIL abort_beat1 got %02h expected b1", rd_data_o); miscompares++; end
    vectors++; if (err_o !== 1'b0) begin $display("FAIL abort_noerr got %0b expected 0", err_o); miscompares++; end
  endtask

  task automatic test_release_empty();
    release_head();
    vectors++; if (occupancy_o !== 3'd0 || err_o !== 1'b0) begin $display("FAIL last_rel got occ %0d err %0b expected 0/0", occupancy_o, err_o); miscompares++; end
    release_head();
    vectors++; if (err_o !== 1'b1) begin $display("FAIL empty_rel_err got %0b expected 1", err_o); miscompares++; end
    vectors++; if (occupancy_o !== 3'd0 || rd_bank_o !== 2'd2) begin $display("FAIL empty_rel_state got occ %0d bank %0d expected 0/2", occupancy_o, rd_bank_o); miscompares++; end
    tick(); tick(); tick();
    vectors++; if (err_o !== 1'b1) begin $display("FAIL err_sticky got %0b expected 1", err_o); miscompares++; end
  endtask

  task automatic test_write_full();
    test_reset();
    for (int k = 0; k < 4; k++) fill_chunk(8'(k));
    vectors++; if (occupancy_o !== 3'd4 || wr_ready_o !== 1'b0) begin $display("FAIL refull got occ %0d ready %0b expected 4/0", occupancy_o, wr_ready_o); miscompares++; end
    put_beat(8'hFF, 0, 1'b0);
    $display("write while full -> occ=%0d err=%0d", occupancy_o, err_o);
    vectors++; if (err_o !== 1'b1) begin $display("FAIL full_wr_err got %0b expected 1", err_o); miscompares++; end
    vectors++; if (occupancy_o !== 3'd4 || wr_bank_o !== 2'd0 || rd_bank_o !== 2'd0) begin $display("FAIL full_wr_state got occ %0d wr %0d rd %0d expected 4/0/0", occupancy_o, wr_bank_o, rd_bank_o); miscompares++; end
  endtask

  task automatic test_cycle_banks();
    rd_dat_addr_i = 8'd0; rd_sparsemap_addr_i = 2'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (rd_bank_o !== 2'(k)) begin $display("FAIL cyc_bank got %0d expected %0d", rd_bank_o, k); miscompares++; end
      vectors++; if (rd_data_o !== 8'(k)) begin $display("FAIL cyc_data got %02h expected %02h", rd_data_o, k); miscompares++; end
      vectors++; if (rd_sparsemap_o !== {8'(k), 8'h00, 8'h03, 8'hA5}) begin $display("FAIL cyc_smap got %08h expected %02h0003a5", rd_sparsemap_o, k); miscompares++; end
      release_head();
    end
    tick();
    vectors++; if (rd_data_o !== 8'h00 || rd_bank_valid_o !== 1'b0) begin $display("FAIL drained got data %02h valid %0b expected 0/0", rd_data_o, rd_bank_valid_o); miscompares++; end
  endtask

  task automatic test_reset_midfill();
    put_beat(8'h77, 0, 1'b0);
    put_beat(8'h77, 1, 1'b0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    $display("reset mid-fill -> occ=%0d err=%0d", occupancy_o, err_o);
    vectors++; if (occupancy_o !== 3'd0 || err_o !== 1'b0) begin $display("FAIL midrst_occ_err got %0d/%0b expected 0/0", occupancy_o, err_o); miscompares++; end
    vectors++; if (wr_bank_o !== 2'd0 || rd_bank_o !== 2'd0 || rd_bank_valid_o !== 1'b0) begin $display("FAIL midrst_ptrs got %0d/%0d/%0b expected 0/0/0", wr_bank_o, rd_bank_o, rd_bank_valid_o); miscompares++; end
    vectors++; if (rd_data_o !== 8'h00 || rd_sparsemap_o !== '0) begin $display("FAIL midrst_rd got %02h/%08h expected 0/0", rd_data_o, rd_sparsemap_o); miscompares++; end
    for (int b = 0; b < 3; b++) put_beat(8'h5A, b, 1'b0);
    vectors++; if (occupancy_o !== 3'd0) begin $display("FAIL midrst_partial got occ %0d expected 0", occupancy_o); miscompares++; end
    put_beat(8'h5A, 3, 1'b0);
    vectors++; if (occupancy_o !== 3'd1) begin $display("FAIL midrst_refill got occ %0d expected 1", occupancy_o); miscompares++; end
    tick();
    vectors++; if (rd_data_o !== 8'h5A) begin $display("FAIL midrst_data got %02h expected 5a", rd_data_o); miscompares++; end
  endtask

  initial begin
    tick();
    test_reset();
    test_fill_full();
    test_release_from_full();
    test_back_to_back();
    test_abort();
    test_release_empty();
    test_write_full();
    test_cycle_banks();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
